// File: rtl/max_exp_window_ctrl.sv
// -----------------------------------------------------------------------------
// max_exp_window_ctrl
//
// Buffered maximum-exponent controller for the 9-term FP16 MAC alignment
// stage. It collects one exponent/skip pair per accepted beat, reports the
// window maximum, then streams one alignment shift per term (max - exp) to the
// mantissa shifter in arrival order.
//
// Optional feature: define MAXEXP_SHIFT_SAT_EN to clamp shift_amt at
// SHIFT_MAX and flag the clamp on shift_sat. Without the macro, shift_amt
// carries the full difference and shift_sat is held at 0.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   in_valid     exponent beat offered          (in)
//   in_ready     controller accepts a beat      (out)
//   in_exp       term exponent                  (in,  EXP_W)
//   in_skip      term skipped, exponent as 0    (in)
//   max_valid    one-cycle pulse on max_exp update (out)
//   max_exp      window maximum, held until next report (out, EXP_W)
//   shift_valid  shift beat presented           (out)
//   shift_ready  downstream accepts shift beat  (in)
//   shift_amt    max_exp - term exponent        (out, EXP_W)
//   shift_skip   term was skipped               (out)
//   shift_idx    term index in arrival order    (out, 4)
//   shift_last   marks term N-1                 (out)
//   shift_sat    shift_amt was clamped          (out)
//   busy         not idle in COLLECT with cnt=0 (out)
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. A producer holds its payload stable while valid is high and ready is
// low; valid never depends combinationally on ready. Every output here is a
// flop, so there is no combinational path from in_valid or shift_ready to any
// output.
// -----------------------------------------------------------------------------
module max_exp_window_ctrl #(
    parameter int EXP_W     = 6,
    parameter int N         = 9,
    parameter int SHIFT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_skip,
    output logic             max_valid,
    output logic [EXP_W-1:0] max_exp,
    output logic             shift_valid,
    input  logic             shift_ready,
    output logic [EXP_W-1:0] shift_amt,
    output logic             shift_skip,
    output logic [3:0]       shift_idx,
    output logic             shift_last,
    output logic             shift_sat,
    output logic             busy
);

`ifdef MAXEXP_SHIFT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [3:0]       LAST        = 4'(N - 1);
    localparam logic [EXP_W-1:0] SHIFT_CLAMP = SHIFT_MAX[EXP_W-1:0];

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        REPORT  = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [EXP_W-1:0] run_max_q, run_max_d;
    logic [EXP_W-1:0] exp_buf [N];
    logic [N-1:0]     skip_buf;

    logic             accept_in;
    logic             accept_shift;
    logic             last_shift;
    logic             load_shift;
    logic [EXP_W-1:0] in_exp_eff;
    logic [EXP_W-1:0] diff;
    logic [EXP_W-1:0] amt_d;
    logic             sat_d;
    logic             skip_d;

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        run_max_d    = run_max_q;
        accept_in    = (state_q == COLLECT) && in_valid;
        accept_shift = (state_q == DRAIN) && shift_valid && shift_ready;
        last_shift   = (idx_q == LAST);
        in_exp_eff   = in_skip ? '0 : in_exp;

        case (state_q)
            COLLECT: begin
                if (accept_in) begin
                    // Strict compare: ties keep the current maximum.
                    if (in_exp_eff > run_max_q) begin
                        run_max_d = in_exp_eff;
                    end
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = REPORT;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            REPORT: begin
                state_d = DRAIN;
                idx_d   = '0;
            end
            DRAIN: begin
                if (accept_shift) begin
                    if (last_shift) begin
                        state_d   = COLLECT;
                        cnt_d     = '0;
                        idx_d     = '0;
                        run_max_d = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d   = COLLECT;
                cnt_d     = '0;
                idx_d     = '0;
                run_max_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------- shift beat payload
    // The next beat is loaded when leaving REPORT (idx 0) and on every
    // non-final downstream accept. max_exp is already valid during REPORT, so
    // the subtraction always uses the registered maximum, which bounds every
    // stored exponent and cannot underflow.
    always_comb begin
        load_shift = (state_q == REPORT) || (accept_shift && !last_shift);
        skip_d     = skip_buf[idx_d];
        diff       = max_exp - exp_buf[idx_d];
        amt_d      = diff;
        sat_d      = 1'b0;
        if (skip_d) begin
            amt_d = '0;
        end else if (SAT_EN && (diff > SHIFT_CLAMP)) begin
            amt_d = SHIFT_CLAMP;
            sat_d = 1'b1;
        end
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            idx_q       <= '0;
            run_max_q   <= '0;
            skip_buf    <= '0;
            for (int i = 0; i < N; i++) begin
                exp_buf[i] <= '0;
            end
            in_ready    <= 1'b1;
            max_valid   <= 1'b0;
            max_exp     <= '0;
            shift_valid <= 1'b0;
            shift_amt   <= '0;
            shift_skip  <= 1'b0;
            shift_idx   <= '0;
            shift_last  <= 1'b0;
            shift_sat   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            run_max_q <= run_max_d;

            if (accept_in) begin
                exp_buf[cnt_q]  <= in_exp_eff;
                skip_buf[cnt_q] <= in_skip;
            end

            in_ready  <= (state_d == COLLECT);
            max_valid <= (state_d == REPORT);
            busy      <= !((state_d == COLLECT) && (cnt_d == '0));

            if (state_d == REPORT) begin
                max_exp <= run_max_d;
            end

            if (load_shift) begin
                shift_valid <= 1'b1;
                shift_amt   <= amt_d;
                shift_skip  <= skip_d;
                shift_idx   <= idx_d;
                shift_last  <= (idx_d == LAST);
                shift_sat   <= sat_d;
            end else if (accept_shift && last_shift) begin
                shift_valid <= 1'b0;
                shift_amt   <= '0;
                shift_skip  <= 1'b0;
                shift_idx   <= '0;
                shift_last  <= 1'b0;
                shift_sat   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/max_exp_window_ctrl.md
# max_exp_window_ctrl

Sequential controller that feeds the 9-term FP16 MAC alignment stage. It collects one exponent/skip pair per accepted beat for a 9-product window and tracks the window's maximum exponent. It then reports that maximum and streams one alignment shift amount per term (max − exp) to the mantissa shifter. It sits between the product-exponent generator and the alignment shifters, replacing a flat 9-input max tree with a buffered, handshaked schedule.

## Interface
- `EXP_W`, default 6: exponent width (FP16 exponent plus carry bit).
- `N`, default 9: terms per window.
- `SHIFT_MAX`, default 15: shift clamp value; used only when `MAXEXP_SHIFT_SAT_EN` is defined.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  an exponent beat is offered.
- `in_ready`  out  1  controller accepts a beat.
- `in_exp`  in  EXP_W  term exponent.
- `in_skip`  in  1  term is skipped; its exponent is treated as 0.
- `max_valid`  out  1  one-cycle pulse when `max_exp` is updated.
- `max_exp`  out  EXP_W  window maximum exponent; holds until the next report.
- `shift_valid`  out  1  a shift beat is presented.
- `shift_ready`  in  1  downstream accepts the shift beat.
- `shift_amt`  out  EXP_W  max_exp − term exponent.
- `shift_skip`  out  1  term was skipped.
- `shift_idx`  out  4  term index, 0..N−1, in arrival order.
- `shift_last`  out  1  marks term N−1.
- `shift_sat`  out  1  `shift_amt` was clamped (configuration-dependent).
- `busy`  out  1  high whenever the state is not COLLECT with cnt=0.

## Operation
- States: COLLECT, REPORT, DRAIN. Reset enters COLLECT with cnt=0 and running max=0.
- COLLECT:
  - `in_ready`=1.
  - On each accept: `buf[cnt]` ← (`in_skip` ? 0 : `in_exp`), `skipbuf[cnt]` ← `in_skip`.
  - Running max ← max(running max, stored exponent). Compare is unsigned; ties leave it unchanged.
  - cnt increments. The accept at cnt=N−1 moves to REPORT.
- REPORT: one cycle. `max_exp` ← running max (registered); `max_valid`=1; `in_ready`=0. Next state is DRAIN with idx=0.
- DRAIN:
  - `shift_valid`=1; `shift_amt` = `max_exp` − `buf[idx]`. A skipped term gives `shift_amt`=0 and `shift_skip`=1.
  - `shift_idx`=idx; `shift_last`=(idx==N−1).
  - Outputs stay stable while `shift_ready`=0.
  - On accept, idx increments. The accept of idx=N−1 returns to COLLECT with cnt=0 and running max=0.
- `in_ready`=0 in REPORT and DRAIN.
- All terms skipped: `max_exp`=0, every beat has `shift_skip`=1 and `shift_amt`=0.
- Subtraction never underflows, because max ≥ every stored exponent.

## Timing
- Reset values: `in_ready`=1, `max_valid`=0, `max_exp`=0, `shift_valid`=0, `shift_amt`=0, `shift_skip`=0, `shift_idx`=0, `shift_last`=0, `shift_sat`=0, `busy`=0. Buffers are cleared.
- The last input is accepted in cycle T. `max_valid` is high in T+1. The first `shift_valid` is high in T+2.
- Minimum window period: N + 1 + N = 19 cycles, when in_valid and shift_ready are held high.
- All outputs are registered. There is no combinational path from `in_valid` or `shift_ready` to any output.
- Gaps in `in_valid` stall COLLECT without loss. Gaps in `shift_ready` stall DRAIN.
- `rst` mid-window, in any state, aborts the window on the next edge: partial data is discarded, outputs take reset values, and no `max_valid` is issued.

## Configuration
- `MAXEXP_SHIFT_SAT_EN` defined:
  - When max − exp > `SHIFT_MAX`, `shift_amt` = `SHIFT_MAX` and `shift_sat`=1.
  - Otherwise `shift_sat`=0.
  - Skipped terms never set `shift_sat`.
- Not defined: `shift_amt` carries the full difference and `shift_sat` is tied to 0.

## Test plan
- Exps 10,3,17,17,0,5,9,1,2, no skips, no stalls, macro off → `max_valid` one cycle after the 9th accept, `max_exp`=17. Shifts are 7,14,0,0,17,12,8,16,15, with `shift_last` only on idx 8.
- Same window with the macro on and `SHIFT_MAX`=15 → shifts 7,14,0,0,15,12,8,15,15. `shift_sat`=1 on idx 4 and 7 only.
- Skip mask on terms 0 and 2 with exps 40,3,50,…, remaining max 17 → `max_exp`=17. idx 0 and 2 give `shift_skip`=1 and `shift_amt`=0.
- All 9 skipped → `max_exp`=0 and nine beats with `shift_skip`=1.
- `shift_ready` toggled 1,0,0,1… → each beat is held stable until accepted. `in_ready` stays 0 until the idx-8 accept, then is 1 on the next cycle.
- `rst` asserted after 5 accepts → next cycle: COLLECT, `busy`=0, no `max_valid`. A fresh 9-beat window then reports the correct max, with the earlier data not included.
